acc_mem_order_ctrl: RTL



---
 rtl/acc_mem_order_ctrl_pkg.sv | 10 +
 rtl/acc_outstanding_cnt.sv | 45 ++++
 rtl/acc_mem_order_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/acc_mem_order_ctrl_pkg.sv
// Shared types for the accelerator memory-ordering controller.
package acc_mem_order_ctrl_pkg;

    typedef enum logic [1:0] {
        ACC_ORD_IDLE  = 2'd0,
        ACC_ORD_DRAIN = 2'd1,
        ACC_ORD_DONE  = 2'd2
    } acc_ord_state_e;

endpackage

// File: rtl/acc_outstanding_cnt.sv
// Saturating up/down counter of in-flight accelerator memory operations with a sticky protocol error.
module acc_outstanding_cnt #(
    parameter int unsigned MAX_CNT = 4,
    parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             disp_i,
    input  logic             complete_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_CNT);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             err_d, err_q;

    // Overflow and underflow both hold the count and flag the error.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (disp_i && !complete_i) begin
            if (cnt_q == CntMax) err_d = 1'b1;
            else                 cnt_d = cnt_q + CNT_W'(1);
        end else if (!disp_i && complete_i) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/acc_mem_order_ctrl.sv
// Issue-side memory-ordering stall for accelerator loads/stores, with fence drain FSM.
//   state | meaning
//   IDLE  | no fence in progress; ordering and capacity stalls only
//   DRAIN | fence waiting for all accelerator memory ops to complete; stall everything
//   DONE  | drain finished; fence issues this cycle, then back to IDLE
module acc_mem_order_ctrl
    import acc_mem_order_ctrl_pkg::*;
#(
    parameter int unsigned NR_OUTSTANDING = 4,
    parameter int unsigned CNT_W          = $clog2(NR_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             acc_cons_en_i,
    input  logic             acc_ld_disp_i,
    input  logic             acc_st_disp_i,
    input  logic             acc_ld_complete_i,
    input  logic             acc_st_complete_i,
    input  logic             issue_valid_i,
    input  logic             issue_is_ld_i,
    input  logic             issue_is_st_i,
    input  logic             issue_is_acc_i,
    input  logic             issue_is_fence_i,
    output logic             stall_o,
    output logic [CNT_W-1:0] acc_ld_cnt_o,
    output logic [CNT_W-1:0] acc_st_cnt_o,
    output logic             drain_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(NR_OUTSTANDING);

    logic [CNT_W-1:0] ld_cnt, st_cnt;
    logic             ld_err, st_err;
    logic             ld_pend, st_pend, any_pend, fence_v;
    logic             order_stall, cap_stall, fence_stall;
    acc_ord_state_e   state_d, state_q;
    logic             drain_d, drain_q;

    acc_outstanding_cnt #(.MAX_CNT(NR_OUTSTANDING), .CNT_W(CNT_W)) u_ld_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .disp_i     (acc_ld_disp_i),
        .complete_i (acc_ld_complete_i),
        .cnt_o      (ld_cnt),
        .err_o      (ld_err)
    );

    acc_outstanding_cnt #(.MAX_CNT(NR_OUTSTANDING), .CNT_W(CNT_W)) u_st_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .disp_i     (acc_st_disp_i),
        .complete_i (acc_st_complete_i),
        .cnt_o      (st_cnt),
        .err_o      (st_err)
    );

    // Pending includes a dispatch in this very cycle; completes never feed the stall.
    always_comb begin
        ld_pend     = (ld_cnt != '0) | acc_ld_disp_i;
        st_pend     = (st_cnt != '0) | acc_st_disp_i;
        any_pend    = ld_pend | st_pend;
        fence_v     = issue_valid_i & issue_is_fence_i;
        order_stall = issue_valid_i & acc_cons_en_i &
                      ((issue_is_ld_i & st_pend) | (issue_is_st_i & any_pend));
        cap_stall   = issue_valid_i & issue_is_acc_i & ((ld_cnt == CntMax) | (st_cnt == CntMax));
        fence_stall = (state_q == ACC_ORD_IDLE) & fence_v & any_pend;
        stall_o     = ~flush_i & ((state_q == ACC_ORD_DRAIN) | order_stall | cap_stall | fence_stall);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC_ORD_IDLE:  if (fence_v && any_pend) state_d = ACC_ORD_DRAIN;
            ACC_ORD_DRAIN: if (ld_cnt == '0 && st_cnt == '0 && !acc_ld_disp_i && !acc_st_disp_i)
                               state_d = ACC_ORD_DONE;
            ACC_ORD_DONE:  state_d = ACC_ORD_IDLE;
            default:       state_d = ACC_ORD_IDLE;
        endcase
        if (flush_i) state_d = ACC_ORD_IDLE;
        drain_d = (state_d == ACC_ORD_DRAIN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACC_ORD_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign acc_ld_cnt_o = ld_cnt;
    assign acc_st_cnt_o = st_cnt;
    assign drain_o      = drain_q;
    assign err_o        = ld_err | st_err;

endmodule
